inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the byte-wide instruction memory (inMem, 8b per entry, big-endian words).
//  Issues 4 sequential byte reads per instruction and assembles them MSB-first into a 32b word.
//  Presents the word to decode with a valid/ready handshake.
//  Owns the PC: +4 per accepted instruction, load on branch/jump redirect. Sits between PC logic and decode.
// PARAMETERS
//  AW        32   byte-address width of PC and mem_addr
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  mem_rd          out  1   byte read strobe to instruction memory
//  mem_addr        out  AW  byte address of current read
//  mem_rdata       in   8   read byte, valid exactly 1 cycle after mem_rd
//  redirect_valid  in   1   load new PC (branch/jump taken)
//  redirect_pc     in   AW  redirect target
//  inst_valid      out  1   inst/inst_pc hold a complete instruction
//  inst_ready      in   1   decode accepts instruction
//  inst            out  32  {b[pc], b[pc+1], b[pc+2], b[pc+3]}
//  inst_pc         out  AW  address of inst
//  misalign_err    out  1   only with IF_MISALIGN_TRAP_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=FETCH, pc=RESET_PC, byte_idx=0, mem_rd=0, inst_valid=0, inst=0, inst_pc=0, misalign_err=0.
//  States: FETCH -> DRAIN -> HOLD -> FETCH.
//   FETCH: mem_rd=1, mem_addr=pc+byte_idx; byte_idx 0..3; byte_idx==3 -> DRAIN.
//   DRAIN: mem_rd=0; capture last byte; -> HOLD with inst_valid=1, inst_pc=pc.
//   HOLD: inst_valid=1, inst/inst_pc stable; inst_valid&inst_ready -> pc+=4, inst_valid=0, -> FETCH.
//  Byte capture: each cycle after a tagged-live mem_rd, shift mem_rdata into assembler MSB-first.
//  Latency: first mem_rd at cycle 0 -> inst_valid high at cycle 5; 6 cycles/instr at inst_ready=1.
//  Redirect (any state, one cycle): pc<=redirect_pc, byte_idx<=0, inst_valid<=0, assembler cleared,
//   state<=FETCH; byte returning next cycle from old stream is discarded (live tag cleared).
//  Redirect + handshake same cycle: instruction counts as consumed; pc takes redirect_pc, not pc+4.
//  Redirect overrides any other next-pc; mem_rd still driven in the redirect cycle (result discarded).
//  inst_ready while inst_valid=0: ignored.
//  PC arithmetic mod 2^AW; pc+byte_idx and pc+4 wrap silently at top of address space.
//  inst/inst_pc change only on entry to HOLD; hold last value otherwise.
//  Reset mid-fetch: in-flight byte ignored; first post-reset mem_rd at first clk edge after rst low.
// CONFIGURATION
//  IF_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> no fetch, state=HOLD with inst_valid=0,
//   misalign_err=1 (sticky) until next redirect or reset; aligned redirect clears it.
//  Undefined: port absent; misaligned targets fetched byte-by-byte as given (no alignment check).
// STRUCTURE
//  Shared package fetch_pkg: state enum {FETCH, DRAIN, HOLD}, INST_BYTES=4, PC_STEP=4, RESET_PC default.
//  Sub-module inst_byte_assembler: 32b shift register, shift_en/clear/byte_in, word_out.
//  Top keeps FSM, pc, byte_idx, live tag, output registers.
// TESTING
//  Mem bytes 0..7 = 20 08 00 05 8C 09 00 04, inst_ready=1 -> inst 0x20080005 @pc 0 (cyc 5), 0x8C090004 @pc 4.
//  inst_ready=0 for 10 cycles in HOLD -> inst/inst_pc stable, mem_rd=0, pc unchanged; then accept -> pc=4.
//  redirect_pc=0x40 during FETCH byte_idx=2 -> old byte dropped, next mem_addr 0x40..0x43, inst_pc=0x40.
//  redirect_pc=0x10 in same cycle as handshake of pc 0 -> next inst_pc=0x10, not 0x4.
//  rst asserted mid-FETCH -> outputs reset immediately (no clk); after release fetch restarts at RESET_PC.
//  IF_MISALIGN_TRAP_EN: redirect 0x42 -> misalign_err=1, no mem_rd; redirect 0x44 -> err=0, fetch 0x44.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam int INST_BYTES = 4;
    localparam int PC_STEP    = 4;
    localparam int IDX_W      = $clog2(INST_BYTES);
    localparam int WORD_W     = 8 * INST_BYTES;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Memory, redirect and decode handshake signals of the fetch sequencer.
// misalign_err exists only when IF_MISALIGN_TRAP_EN is defined.
interface inst_fetch_ctrl_if #(
    parameter int AW = 32
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
`ifdef IF_MISALIGN_TRAP_EN
    logic          misalign_err;

    modport master (
        output mem_rd, mem_addr, inst_valid, inst, inst_pc, misalign_err,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  mem_rd, mem_addr, inst_valid, inst, inst_pc, misalign_err,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
`else
    modport master (
        output mem_rd, mem_addr, inst_valid, inst, inst_pc,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  mem_rd, mem_addr, inst_valid, inst, inst_pc,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
`endif
endinterface

// File: rtl/inst_byte_assembler.sv
// MSB-first byte shift register building a big-endian instruction word.
// word_out already includes the byte shifted in this cycle, so the caller can capture on the final shift.
module inst_byte_assembler
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_out
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clear) begin
            word_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[WORD_W-9:0], byte_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_out = word_d;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: four byte reads per instruction, valid/ready to decode, PC ownership.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect parks in HOLD with sticky misalign_err.
//
// state | meaning
// FETCH | issue byte reads pc+0..pc+3
// DRAIN | last byte returns, word captured
// HOLD  | instruction presented until accepted (or parked on misalign)
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_ctrl_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              live_q, live_d;
    logic              run_q, run_d;
    logic              inst_valid_q, inst_valid_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [AW-1:0]     inst_pc_q, inst_pc_d;
    logic              mem_rd;
    logic [WORD_W-1:0] asm_word;
`ifdef IF_MISALIGN_TRAP_EN
    logic              err_q, err_d;
`endif

    // run_q holds reads off until the first edge after reset release
    assign mem_rd = run_q && (state_q == FETCH);

    inst_byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .shift_en (live_q),
        .clear    (bus.redirect_valid),
        .byte_in  (bus.mem_rdata),
        .word_out (asm_word)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        idx_d        = idx_q;
        run_d        = 1'b1;
        live_d       = mem_rd && !bus.redirect_valid;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
`ifdef IF_MISALIGN_TRAP_EN
        err_d        = err_q;
`endif

        case (state_q)
            FETCH: begin
                if (run_q) begin
                    if (idx_q == IDX_W'(INST_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_d      = HOLD;
                inst_valid_d = 1'b1;
                inst_d       = asm_word;
                inst_pc_d    = pc_q;
            end
            HOLD: begin
                if (inst_valid_q && bus.inst_ready) begin
                    pc_d         = pc_q + AW'(PC_STEP);
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // redirect wins over every other next-state, including a same-cycle handshake
        if (bus.redirect_valid) begin
            pc_d         = bus.redirect_pc;
            idx_d        = '0;
            inst_valid_d = 1'b0;
            inst_d       = inst_q;
            inst_pc_d    = inst_pc_q;
            state_d      = FETCH;
`ifdef IF_MISALIGN_TRAP_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d = HOLD;
                err_d   = 1'b1;
            end else begin
                err_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            idx_q        <= '0;
            live_q       <= 1'b0;
            run_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            live_q       <= live_d;
            run_q        <= run_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.misalign_err = err_q;
`endif

    assign bus.mem_rd     = mem_rd;
    assign bus.mem_addr   = pc_q + AW'(idx_q);
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

endmodule
